// File: rtl/aes_pkg.sv
// Shared AES types, constants and round primitives used by the cipher controller.
// Block bytes are numbered from the MSB; byte 4*c+r holds row r of column c.
package aes_pkg;

    localparam int AES_BLK   = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_MAX    = 14;
    localparam int RK_MAX    = AES_BLK * (NR_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_state_e;

    // Keys are left-justified in an RK_MAX bus so one slicer serves every key size.
    function automatic logic [AES_BLK-1:0] rk_slice(input logic [RK_MAX-1:0] keys, input int r);
        return keys[RK_MAX-1-AES_BLK*r -: AES_BLK];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // S-box as inverse (a^254, zero maps to zero) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = a;
        for (int i = 1; i < 8; i++) begin
            p   = gfMul(p, p);
            inv = gfMul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [AES_BLK-1:0] subBytes(input logic [AES_BLK-1:0] b);
        logic [AES_BLK-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[AES_BLK-1-8*i -: 8] = sbox(b[AES_BLK-1-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [AES_BLK-1:0] shiftRows(input logic [AES_BLK-1:0] b);
        logic [AES_BLK-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[AES_BLK-1-8*(4*c+r) -: 8] = b[AES_BLK-1-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [AES_BLK-1:0] mixColumns(input logic [AES_BLK-1:0] b);
        logic [AES_BLK-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[AES_BLK-1-32*c -: 8];
            a1 = b[AES_BLK-9-32*c -: 8];
            a2 = b[AES_BLK-17-32*c -: 8];
            a3 = b[AES_BLK-25-32*c -: 8];
            o[AES_BLK-1-32*c  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[AES_BLK-9-32*c  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[AES_BLK-17-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[AES_BLK-25-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [AES_BLK-1:0] addRoundKey(input logic [AES_BLK-1:0] b,
                                                       input logic [AES_BLK-1:0] k);
        return b ^ k;
    endfunction

    function automatic logic [AES_BLK-1:0] encryptRound(input logic [AES_BLK-1:0] b,
                                                        input logic [AES_BLK-1:0] k);
        return addRoundKey(mixColumns(shiftRows(subBytes(b))), k);
    endfunction

endpackage

// File: rtl/aes_final_round.sv
// Last AES round: SubBytes and ShiftRows without MixColumns, then AddRoundKey.
module aes_final_round
    import aes_pkg::*;
(
    input  logic [AES_BLK-1:0] stateIn,
    input  logic [AES_BLK-1:0] roundKey,
    output logic [AES_BLK-1:0] stateOut
);

    assign stateOut = addRoundKey(shiftRows(subBytes(stateIn)), roundKey);

endmodule

// File: rtl/aes_cipher_ctrl.sv
// Iterative AES encryption controller: one round per clock between valid/ready
// handshakes, with keys latched at accept so inputs may change during a run.
module aes_cipher_ctrl
    import aes_pkg::*;
#(
    parameter  int Nr  = NR_AES128,
    localparam int RKW = AES_BLK * (Nr + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AES_BLK-1:0] plaintext,
    input  logic [RKW-1:0]     round_keys,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AES_BLK-1:0] ciphertext,
    output logic               busy,
    output logic [3:0]         round_idx
);

    ctrl_state_e        st, stNext;
    logic [AES_BLK-1:0] stateQ, stateD;
    logic [AES_BLK-1:0] ctQ, ctD;
    logic [RKW-1:0]     keyQ, keyD;
    logic [3:0]         idxQ, idxD;
    logic               ovQ, ovD;
    logic               accept;
    logic [RK_MAX-1:0]  keyPad;
    logic [AES_BLK-1:0] curKey;
    logic [AES_BLK-1:0] midOut;
    logic [AES_BLK-1:0] finalOut;

    assign keyPad = RK_MAX'(keyQ) << (RK_MAX - RKW);
    // One key mux serves both the middle rounds and the final round.
    assign curKey = rk_slice(keyPad, int'(idxQ));
    assign midOut = encryptRound(stateQ, curKey);

    aes_final_round u_final (
        .stateIn (stateQ),
        .roundKey(curKey),
        .stateOut(finalOut)
    );

    assign in_ready   = (st == IDLE) | ((st == DONE) & out_ready);
    assign accept     = in_valid & in_ready;
    assign busy       = (st == RUN);
    assign out_valid  = ovQ;
    assign ciphertext = ctQ;
    assign round_idx  = idxQ;

    always_comb begin
        stNext = st;
        stateD = stateQ;
        keyD   = keyQ;
        idxD   = idxQ;
        ovD    = ovQ;
        ctD    = ctQ;
        case (st)
            RUN: begin
                if (idxQ < 4'(Nr)) begin
                    stateD = midOut;
                    idxD   = idxQ + 4'd1;
                end else begin
                    ctD    = finalOut;
                    ovD    = 1'b1;
                    stNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ovD    = 1'b0;
                    idxD   = 4'd0;
                    stNext = IDLE;
                end
            end
            default: ;
        endcase
        // Accept from DONE overrides the return to IDLE: back-to-back blocks.
        if (accept) begin
            keyD   = round_keys;
            stateD = addRoundKey(plaintext, round_keys[RKW-1 -: AES_BLK]);
            idxD   = 4'd1;
            ovD    = 1'b0;
            stNext = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            stateQ <= '0;
            keyQ   <= '0;
            idxQ   <= 4'd0;
            ovQ    <= 1'b0;
            ctQ    <= '0;
        end else begin
            st     <= stNext;
            stateQ <= stateD;
            keyQ   <= keyD;
            idxQ   <= idxD;
            ovQ    <= ovD;
            ctQ    <= ctD;
        end
    end

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Self-checking bench for aes_cipher_ctrl: FIPS-197 vectors, handshake corner
// cases and random blocks against an array-based AES-128 reference.
module tb_aes_cipher_ctrl;

    localparam int NR  = 10;
    localparam int RKW = 128 * (NR + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   plaintext = '0;
    logic [RKW-1:0] round_keys = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   ciphertext;
    logic           busy;
    logic [3:0]     round_idx;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox [256];

    aes_cipher_ctrl #(.Nr(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plaintext (plaintext),
        .round_keys(round_keys),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ciphertext(ciphertext),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // S-box table generated with the classic log/antilog walk over GF(2^8).
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [RKW-1:0] expand(input logic [127:0] key);
        logic [31:0]    w [44];
        logic [31:0]    tmp;
        logic [7:0]     rc;
        logic [RKW-1:0] o;
        rc = 8'h01;
        o  = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]] ^ rc, sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) o[RKW-1-32*i -: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] aesRef(input logic [RKW-1:0] rk, input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k;
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
        for (int rnd = 0; rnd <= NR; rnd++) begin
            if (rnd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r][c] = sbox[s[r][(c+r)%4]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (rnd < NR)
                            s[r][c] = xt(t[r][c]) ^ xt(t[(r+1)%4][c]) ^ t[(r+1)%4][c]
                                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                        else
                            s[r][c] = t[r][c];
            end
            k = rk[RKW-1-128*rnd -: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // Presents one block from IDLE, optionally scrambles inputs after accept, and
    // steps until out_valid; lat counts cycles from the accept cycle.
    task automatic runBlock(input logic [127:0] pt, input logic [RKW-1:0] rk, input bit scramble,
                            output int lat, output int busyCnt);
        plaintext  = pt;
        round_keys = rk;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        if (scramble) begin
            plaintext  = '1;
            round_keys = '1;
        end
        lat     = 1;
        busyCnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busyCnt++;
            step();
            lat++;
        end
    endtask

    logic [127:0]   pt1, pt2, ct1, ct2, key, pt, exp;
    logic [RKW-1:0] rk1, rk2, rk;
    int             lat, busyCnt, n;
    bit             scr;

    initial begin
        buildSbox();
        pt1 = 128'h00112233445566778899aabbccddeeff;
        rk1 = expand(128'h000102030405060708090a0b0c0d0e0f);
        ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt2 = 128'h3243f6a8885a308d313198a2e0370734;
        rk2 = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        ct2 = 128'h3925841d02dc09fbdc118597196a0b32;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkBit("rst_in_ready", in_ready, 1'b1);
        checkBit("rst_out_valid", out_valid, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        check("rst_ct", ciphertext, '0);
        checkInt("rst_idx", int'(round_idx), 0);

        // FIPS-197 C.1 with out_ready high
        out_ready = 1'b1;
        runBlock(pt1, rk1, 1'b0, lat, busyCnt);
        checkInt("c1_latency", lat, NR + 1);
        checkInt("c1_busy_cycles", busyCnt, NR);
        check("c1_ct", ciphertext, ct1);
        checkInt("c1_idx_done", int'(round_idx), NR);
        step();
        checkBit("c1_drop", out_valid, 1'b0);

        // FIPS-197 B with 20 cycles of backpressure
        out_ready = 1'b0;
        runBlock(pt2, rk2, 1'b0, lat, busyCnt);
        checkInt("b_latency", lat, NR + 1);
        check("b_ct", ciphertext, ct2);
        for (int i = 0; i < 20; i++) begin
            step();
            checkBit("bp_valid_held", out_valid, 1'b1);
            check("bp_ct_held", ciphertext, ct2);
            checkBit("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        checkBit("bp_in_ready_comb", in_ready, 1'b1);
        step();
        checkBit("bp_valid_fall", out_valid, 1'b0);
        checkBit("bp_idle_busy", busy, 1'b0);
        checkInt("bp_idle_idx", int'(round_idx), 0);
        checkBit("bp_idle_ready", in_ready, 1'b1);

        // Back-to-back: vector 1 then vector 2 with in_valid held
        plaintext  = pt1;
        round_keys = rk1;
        in_valid   = 1'b1;
        step();
        plaintext  = pt2;
        round_keys = rk2;
        n = 1;
        while (!out_valid && n < 40) begin step(); n++; end
        checkInt("b2b_lat1", n, NR + 1);
        check("b2b_ct1", ciphertext, ct1);
        checkBit("b2b_ready_done", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        checkBit("b2b_valid_drop", out_valid, 1'b0);
        checkBit("b2b_busy2", busy, 1'b1);
        checkInt("b2b_idx2", int'(round_idx), 1);
        n = 1;
        while (!out_valid && n < 40) begin step(); n++; end
        checkInt("b2b_lat2", n, NR + 1);
        check("b2b_ct2", ciphertext, ct2);
        step();
        checkBit("b2b_end", out_valid, 1'b0);
        checkBit("b2b_no_dup", busy, 1'b0);

        // Reset in the middle of a run
        plaintext  = pt1;
        round_keys = rk1;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin step(); n++; end
        checkInt("mid_idx5", int'(round_idx), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkBit("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ct", ciphertext, '0);
        checkInt("mid_rst_idx", int'(round_idx), 0);
        checkBit("mid_rst_ready", in_ready, 1'b1);
        runBlock(pt1, rk1, 1'b0, lat, busyCnt);
        checkInt("mid_rerun_lat", lat, NR + 1);
        check("mid_rerun_ct", ciphertext, ct1);
        step();

        // Inputs forced to all-ones during the run
        runBlock(pt1, rk1, 1'b1, lat, busyCnt);
        check("stable_ct", ciphertext, ct1);
        step();
        checkBit("stable_end", out_valid, 1'b0);

        // Random blocks with random backpressure
        for (int i = 0; i < 8; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rk  = expand(key);
            exp = aesRef(rk, pt);
            scr = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            runBlock(pt, rk, scr, lat, busyCnt);
            checkInt("rnd_lat", lat, NR + 1);
            check("rnd_ct", ciphertext, exp);
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) begin
                    step();
                    checkBit("rnd_hold", out_valid, 1'b1);
                    check("rnd_ct_hold", ciphertext, exp);
                end
                out_ready = 1'b1;
            end
            step();
            checkBit("rnd_drop", out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
